// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: control state encoding, shift-mode codes
// and the default data width.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic SH_LOGIC = 1'b0;
    localparam logic SH_ARITH = 1'b1;

    localparam int DEF_WIDTH = 32;

endpackage : cpu_pkg

// File: rtl/shift_right_seq_step.sv
// One-bit combinational right shift; the vacated MSB takes the sign bit in
// arithmetic mode and zero in logical mode.
module shift_right_step
    import cpu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] data_o
);

    logic fill;

    assign fill   = (mode_i == SH_ARITH) ? data_i[WIDTH-1] : 1'b0;
    assign data_o = {fill, data_i[WIDTH-1:1]};

endmodule : shift_right_step

// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter (SRL/SRA class): one bit per cycle, with a
// start/busy/done handshake towards the main control FSM.
module shift_right_seq
    import cpu_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               arith_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   data_o
);

    state_t             state_q, state_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0]   data_q,  data_d;
    logic               mode_q,  mode_d;
    logic [WIDTH-1:0]   step_data;

    shift_right_step #(.WIDTH(WIDTH)) u_step (
        .data_i (data_q),
        .mode_i (mode_q),
        .data_o (step_data)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        data_d  = data_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE accepts a new start the same way IDLE does, so
                // operations can run back to back without an idle bubble.
                if (start_i) begin
                    data_d  = data_i;
                    count_d = shamt_i;
                    mode_d  = arith_i;
                    state_d = (shamt_i == '0) ? ST_DONE : ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                data_d  = step_data;
                count_d = count_q - SHAMT_W'(1);
                if (count_q == SHAMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            data_q  <= '0;
            mode_q  <= SH_LOGIC;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
        end
    end

    assign busy_o = (state_q == ST_SHIFT);
    assign done_o = (state_q == ST_DONE);
    assign data_o = data_q;

endmodule : shift_right_seq

// File: tb/tb_shift_right_seq.sv
// Directed-vector bench for shift_right_seq: latency, busy window, result
// value, reset abort and handshake corner cases against hand-computed values.
module tb_shift_right_seq;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic        arith_i;
    logic [31:0] data_i;
    logic [4:0]  shamt_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] data_o;

    int total = 0;
    int bad   = 0;

    shift_right_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .arith_i (arith_i),
        .data_i  (data_i),
        .shamt_i (shamt_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .data_o  (data_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic scramble();
        data_i  = $urandom;
        shamt_i = 5'($urandom_range(31, 0));
        arith_i = 1'($urandom_range(1, 0));
    endtask

    // Called at a negedge with the DUT in IDLE or DONE. Returns at the negedge
    // of the done cycle. hold keeps start high throughout; poke raises start
    // for one mid-shift cycle (0 = never). Operands are scrambled after start.
    task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] s,
                          input logic a, input logic [31:0] exp_d,
                          input bit hold, input int poke);
        int cyc;
        bit busy_ok;
        start_i = 1'b1;
        data_i  = d;
        shamt_i = s;
        arith_i = a;
        @(negedge clk_i);
        cyc     = 1;
        busy_ok = 1'b1;
        start_i = hold || (poke == 1);
        scramble();
        while (done_o !== 1'b1 && cyc < 40) begin
            if (busy_o !== 1'b1) busy_ok = 1'b0;
            @(negedge clk_i);
            cyc++;
            start_i = hold || (poke == cyc);
            scramble();
        end
        chk({tag, " latency"}, 32'(cyc), 32'(s) + 32'd1);
        chk({tag, " data"}, data_o, exp_d);
        chk({tag, " busy at done"}, 32'(busy_o), 32'd0);
        if (s != 5'd0) chk({tag, " busy window"}, 32'(busy_ok), 32'd1);
    endtask

    task automatic after_op(input string tag, input logic [31:0] exp_d);
        start_i = 1'b0;
        @(negedge clk_i);
        chk({tag, " done pulse"}, 32'(done_o), 32'd0);
        chk({tag, " hold"}, data_o, exp_d);
    endtask

    initial begin
        bit seen_done;
        bit seen_busy;

        rst_i   = 1'b0;
        start_i = 1'b0;
        arith_i = 1'b0;
        data_i  = '0;
        shamt_i = '0;
        repeat (2) @(negedge clk_i);
        chk("rst data", data_o, 32'h0);
        chk("rst busy", 32'(busy_o), 32'd0);
        chk("rst done", 32'(done_o), 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);

        run_op("srl4", 32'h8000_0010, 5'd4, 1'b0, 32'h0800_0001, 1'b0, 0);
        after_op("srl4", 32'h0800_0001);

        run_op("sra4", 32'h8000_0010, 5'd4, 1'b1, 32'hF800_0001, 1'b0, 0);
        after_op("sra4", 32'hF800_0001);

        run_op("sra31", 32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000, 1'b0, 0);
        after_op("sra31", 32'h0000_0000);

        run_op("srl31 neg", 32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 1'b0, 0);
        after_op("srl31 neg", 32'h0000_0001);

        run_op("sra31 neg", 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b0, 0);
        after_op("sra31 neg", 32'hFFFF_FFFF);

        run_op("zero", 32'hDEAD_BEEF, 5'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 0);
        after_op("zero", 32'hDEAD_BEEF);

        // Start held high: the second op is accepted in the first op's done cycle.
        run_op("b2b first", 32'h0000_0100, 5'd8, 1'b0, 32'h0000_0001, 1'b1, 0);
        run_op("b2b second", 32'hFFFF_FF00, 5'd4, 1'b1, 32'hFFFF_FFF0, 1'b0, 0);
        after_op("b2b second", 32'hFFFF_FFF0);

        run_op("poke", 32'h8000_0010, 5'd4, 1'b1, 32'hF800_0001, 1'b0, 2);
        after_op("poke", 32'hF800_0001);

        // Reset in the middle of a long shift aborts it.
        start_i = 1'b1;
        data_i  = 32'hF000_0000;
        shamt_i = 5'd20;
        arith_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        chk("mid busy before rst", 32'(busy_o), 32'd1);
        rst_i = 1'b0;
        #1;
        chk("abort data", data_o, 32'h0);
        chk("abort busy", 32'(busy_o), 32'd0);
        chk("abort done", 32'(done_o), 32'd0);
        @(negedge clk_i);
        rst_i     = 1'b1;
        seen_done = 1'b0;
        seen_busy = 1'b0;
        repeat (30) begin
            @(negedge clk_i);
            if (done_o !== 1'b0) seen_done = 1'b1;
            if (busy_o !== 1'b0) seen_busy = 1'b1;
        end
        chk("no done after rst", 32'(seen_done), 32'd0);
        chk("no busy after rst", 32'(seen_busy), 32'd0);
        chk("data after rst", data_o, 32'h0);

        // Mode is cleared by reset: a logical op still zero-fills afterwards.
        run_op("srl after rst", 32'hF000_0000, 5'd4, 1'b0, 32'h0F00_0000, 1'b0, 0);
        after_op("srl after rst", 32'h0F00_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_shift_right_seq

// File: doc/shift_right_seq.md
Name: shift_right_seq

Overview:
- Multi-cycle right-shift unit for the CPU datapath; the right-shift counterpart of the combinational left-shift blocks.
- Executes SRL/SRA/SRLV/SRAV-class operations by shifting one bit per cycle.
- Uses a start/busy/done handshake with the main control FSM.
- The ALU result mux takes data_o when done_o is high.

Parameters:
WIDTH, 32, data width in bits
SHAMT_W, 5, shift-amount width; must satisfy 2**SHAMT_W == WIDTH

Ports:
clk_i  input  1  system clock, rising edge
rst_i  input  1  asynchronous, active-low reset
start_i  input  1  request; sampled only in IDLE or DONE
arith_i  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill); latched at start
data_i  input  WIDTH  operand; latched at start
shamt_i  input  SHAMT_W  shift amount, unsigned 0..WIDTH-1; latched at start
busy_o  output  1  high while in SHIFT
done_o  output  1  one-cycle pulse, result valid
data_o  output  WIDTH  result register

Behaviour:
- Reset (rst_i low, any time, asynchronous):
  - state = IDLE, count = 0.
  - data_o = 0, busy_o = 0, done_o = 0, latched arith = 0.
  - Any in-flight operation is aborted; no done_o follows reset release.
- States: IDLE, SHIFT, DONE (2-bit encoding).
- IDLE:
  - start_i = 1: latch data_i into data_o, shamt_i into count, arith_i into mode.
  - Next state is DONE if shamt_i == 0, else SHIFT.
  - start_i = 0: stay in IDLE.
- SHIFT:
  - Each cycle: data_o <= {fill, data_o[WIDTH-1:1]}; count <= count - 1.
  - fill = data_o[WIDTH-1] if mode is arithmetic, else 0.
  - When count == 1, perform the final shift and go to DONE.
  - start_i is ignored while in SHIFT; no queueing.
- DONE:
  - done_o = 1 for exactly this cycle.
  - start_i = 1 is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- Outputs:
  - busy_o = (state == SHIFT); done_o = (state == DONE); both decoded from state, glitch-free.
  - data_o holds its value after DONE until the next accepted start, which overwrites it with data_i.
- Latency: with start_i sampled high in cycle 0, done_o is high in cycle shamt+1.
  - shamt = 0: 1 cycle.
  - shamt = 31: 32 cycles.
- Width rules:
  - Only the low SHAMT_W bits of the amount are used; no saturation.
  - The sign bit is re-sampled each cycle from data_o[WIDTH-1], which is invariant under arithmetic shift.
- Inputs data_i, shamt_i and arith_i may change freely after start is accepted; only the latched copies are used.

Decomposition:
- Shared package (cpu_pkg):
  - State encoding constants: ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2.
  - Shift-mode constants: SH_LOGIC = 1'b0, SH_ARITH = 1'b1.
  - Default WIDTH = 32.
- One natural sub-module: shift_right_step, a combinational one-bit right shift with fill select.
  - Instantiated once in the datapath register update.
  - Counter and FSM stay in the top module.

Test Plan:
- Reset: drive rst_i low mid-SHIFT (data 0xF000_0000, shamt 20, after 5 cycles) -> data_o = 0, busy_o = 0, done_o = 0 immediately; no done_o pulse after release.
- Logical shift: data 0x8000_0010, shamt 4, arith 0 -> done_o in cycle 5, data_o = 0x0800_0001; busy_o high in cycles 1-4.
- Arithmetic shift: data 0x8000_0010, shamt 4, arith 1 -> data_o = 0xF800_0001; data 0x7FFF_FFFF, shamt 31, arith 1 -> data_o = 0x0000_0000, done_o in cycle 32.
- Zero amount: data 0xDEAD_BEEF, shamt 0 -> done_o in cycle 1, data_o = 0xDEAD_BEEF, busy_o never high.
- Back-to-back: start held high with ops (0x0000_0100, 8, logical) then (0xFFFF_FF00, 4, arith) -> first done_o in cycle 9 with data_o = 0x0000_0001; second accepted in that same cycle, done_o in cycle 14 with data_o = 0xFFFF_FFF0.
- Start while busy: start_i pulsed with new operands during SHIFT -> ignored; result and done timing match the original operation only.
